// File: rtl/axi_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_bridge_pkg
// Description : Shared types and helpers for the core-to-AXI memory bridge.
//               Contains the FSM state encoding, the request owner, the AXI
//               response codes and the byte-strobe helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  // Which core port owns the read that is in flight
  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // AXI response codes
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam logic [1:0] C_RESP_DECERR = 2'b11;

  // Byte strobe for an access of 2**size bytes at byte offset off inside a
  // 64-bit beat; bits shifted past lane 7 are dropped.
  function automatic logic [7:0] size_to_strb(input logic [2:0] size,
                                              input logic [2:0] off);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage : axi_mem_bridge_pkg
`default_nettype wire

// File: rtl/axi_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_bridge_if
// Description : Single-beat AXI4 bus between the bridge (master) and the
//               memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_mem_bridge_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64
) ();

  logic [AXI_ADDR_W-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [2:0]              arsize;
  logic [7:0]              arlen;

  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic [AXI_ADDR_W-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [2:0]              awsize;
  logic [7:0]              awlen;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, arsize, arlen, rready,
    output awaddr, awvalid, awsize, awlen, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, arsize, arlen, rready,
    input  awaddr, awvalid, awsize, awlen, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
  );

endinterface : axi_mem_bridge_if
`default_nettype wire

// File: rtl/axi_mem_bridge_wr_align.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_align
// Description : Places LSB-aligned store data on its byte lanes and builds
//               the matching write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_align
  import axi_mem_bridge_pkg::*;
(
  input  wire logic [2:0]  i_off,
  input  wire logic [2:0]  i_size,
  input  wire logic [63:0] i_data,
  output logic      [63:0] o_wdata,
  output logic      [7:0]  o_wstrb
);

  // Shift data up by the byte offset and derive the strobe for that span
  always_comb begin
    o_wdata = i_data << {i_off, 3'b000};
    o_wstrb = size_to_strb(i_size, i_off);
  end

endmodule : axi_wr_align
`default_nettype wire

// File: rtl/axi_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_bridge
// Description : Arbitrates the core fetch port and load/store port onto one
//               single-beat AXI4 master. Loads/stores win over fetches.
//               Responses return as registered one-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_bridge
  import axi_mem_bridge_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int PC_W       = 64
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  if_core_ready,
  input  wire logic [PC_W-1:0]       if_pc_next,
  output logic                       inst_valid,
  output logic      [31:0]           if_inst,
  output logic      [PC_W-1:0]       if_pc,
  input  wire logic                  re,
  input  wire logic                  we,
  input  wire logic [PC_W-1:0]       data_pc,
  input  wire logic [AXI_DATA_W-1:0] ls_data_o,
  input  wire logic [2:0]            data_size,
  output logic      [AXI_DATA_W-1:0] data_temp,
  output logic                       data_valid,
  output logic                       bus_err,
  axi_mem_bridge_if.master           axi
);

  state_t                r_state, w_next;
  owner_t                r_owner;
  logic [PC_W-1:0]       r_addr;
  logic [AXI_DATA_W-1:0] r_sdata;
  logic [2:0]            r_size;
  logic                  r_aw_done, r_w_done;
  logic                  r_inst_valid, r_data_valid, r_bus_err;
  logic [31:0]           r_if_inst;
  logic [PC_W-1:0]       r_if_pc;
  logic [AXI_DATA_W-1:0] r_data_temp;

  logic w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  logic w_aw_fire, w_w_fire;
  logic [63:0] w_wdata;
  logic [7:0]  w_wstrb;
  logic        w_unused;

  axi_wr_align u_wr_align (
    .i_off   (r_addr[2:0]),
    .i_size  (r_size),
    .i_data  (r_sdata),
    .o_wdata (w_wdata),
    .o_wstrb (w_wstrb)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and bus handshake outputs; valids come only from the state
  always_comb begin
    w_next    = r_state;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    w_aw_fire = 1'b0;
    w_w_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (we)                 w_next = ST_WR_REQ;
        else if (re)            w_next = ST_RD_ADDR;
        else if (if_core_ready) w_next = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        w_arvalid = 1'b1;
        if (axi.arready) w_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        w_rready = 1'b1;
        if (axi.rvalid) w_next = ST_IDLE;
      end
      ST_WR_REQ: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        w_aw_fire = w_awvalid && axi.awready;
        w_w_fire  = w_wvalid && axi.wready;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire))
          w_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        w_bready = 1'b1;
        if (axi.bvalid) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latching, write handshake tracking and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_IF;
      r_addr       <= '0;
      r_sdata      <= '0;
      r_size       <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      r_if_inst    <= '0;
      r_if_pc      <= '0;
      r_data_temp  <= '0;
    end else begin
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (we) begin
            r_owner   <= OWN_DATA;
            r_addr    <= data_pc;
            r_sdata   <= ls_data_o;
            r_size    <= data_size;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else if (re) begin
            r_owner <= OWN_DATA;
            r_addr  <= data_pc;
            r_size  <= data_size;
          end else if (if_core_ready) begin
            r_owner <= OWN_IF;
            r_addr  <= if_pc_next;
            r_size  <= 3'd2;
          end
        end
        ST_WR_REQ: begin
          if (w_aw_fire) r_aw_done <= 1'b1;
          if (w_w_fire)  r_w_done  <= 1'b1;
        end
        ST_RD_DATA: begin
          if (axi.rvalid) begin
            r_bus_err <= (axi.rresp != C_RESP_OKAY);
            if (r_owner == OWN_IF) begin
              r_if_inst    <= r_addr[2] ? axi.rdata[63:32] : axi.rdata[31:0];
              r_if_pc      <= r_addr;
              r_inst_valid <= 1'b1;
            end else begin
              r_data_temp  <= axi.rdata >> {r_addr[2:0], 3'b000};
              r_data_valid <= 1'b1;
            end
          end
        end
        ST_WR_RESP: begin
          if (axi.bvalid) begin
            r_bus_err    <= (axi.bresp != C_RESP_OKAY);
            r_data_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Single-beat transfers: rlast carries no extra information
  assign w_unused = axi.rlast;

  assign axi.araddr  = r_addr[AXI_ADDR_W-1:0];
  assign axi.arvalid = w_arvalid;
  assign axi.arsize  = r_size;
  assign axi.arlen   = 8'd0;
  assign axi.rready  = w_rready;
  assign axi.awaddr  = r_addr[AXI_ADDR_W-1:0];
  assign axi.awvalid = w_awvalid;
  assign axi.awsize  = r_size;
  assign axi.awlen   = 8'd0;
  assign axi.wdata   = w_wvalid ? w_wdata : '0;
  assign axi.wstrb   = w_wvalid ? w_wstrb : '0;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_bready;

  assign inst_valid = r_inst_valid;
  assign if_inst    = r_if_inst;
  assign if_pc      = r_if_pc;
  assign data_temp  = r_data_temp;
  assign data_valid = r_data_valid;
  assign bus_err    = r_bus_err;

endmodule : axi_mem_bridge
`default_nettype wire

// File: tb/tb_axi_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_mem_bridge
// Description : Directed, table-driven bench for axi_mem_bridge with an
//               inline procedural AXI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_core_ready;
  logic [63:0] if_pc_next;
  logic        inst_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        re, we;
  logic [63:0] data_pc;
  logic [63:0] ls_data_o;
  logic [2:0]  data_size;
  logic [63:0] data_temp;
  logic        data_valid;
  logic        bus_err;

  axi_mem_bridge_if #(.AXI_ADDR_W(32), .AXI_DATA_W(64)) axi ();

  axi_mem_bridge #(.AXI_ADDR_W(32), .AXI_DATA_W(64), .PC_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_core_ready (if_core_ready),
    .if_pc_next    (if_pc_next),
    .inst_valid    (inst_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .re            (re),
    .we            (we),
    .data_pc       (data_pc),
    .ls_data_o     (ls_data_o),
    .data_size     (data_size),
    .data_temp     (data_temp),
    .data_valid    (data_valid),
    .bus_err       (bus_err),
    .axi           (axi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] sdata;
    logic [63:0] rdata;
    logic [1:0]  resp;
    int          ar_wait;
    logic [2:0]  e_size;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic [63:0] e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_core();
    if_core_ready = 1'b0;
    re            = 1'b0;
    we            = 1'b0;
    if_pc_next    = 64'hFFFF_FFFF_FFFF_FFF0;
    data_pc       = 64'h0;
    ls_data_o     = '1;
    data_size     = 3'd3;
  endtask

  task automatic clear_slave();
    axi.arready = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b1;
    axi.rvalid  = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bvalid  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    // cycle 0: present the request for one cycle
    case (v.kind)
      0: begin if_core_ready = 1'b1; if_pc_next = v.addr; end
      1: begin re = 1'b1; data_pc = v.addr; data_size = v.size; end
      default: begin we = 1'b1; data_pc = v.addr; data_size = v.size; ls_data_o = v.sdata; end
    endcase
    tick();
    clear_core();  // later input changes must be ignored
    if (v.kind < 2) begin
      chk({tag, "_arvalid"}, {63'd0, axi.arvalid}, 64'd1);
      chk({tag, "_araddr"}, {32'd0, axi.araddr}, {32'd0, v.addr[31:0]});
      chk({tag, "_arsize"}, {61'd0, axi.arsize}, {61'd0, v.e_size});
      for (int i = 0; i < v.ar_wait; i++) begin
        tick();
        chk({tag, "_arvalid_hold"}, {63'd0, axi.arvalid}, 64'd1);
        chk({tag, "_araddr_hold"}, {32'd0, axi.araddr}, {32'd0, v.addr[31:0]});
        chk({tag, "_no_early_pulse"}, {63'd0, inst_valid | data_valid}, 64'd0);
      end
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      chk({tag, "_rready"}, {63'd0, axi.rready}, 64'd1);
      chk({tag, "_arvalid_drop"}, {63'd0, axi.arvalid}, 64'd0);
      axi.rvalid = 1'b1; axi.rdata = v.rdata; axi.rresp = v.resp;
      tick();
      axi.rvalid = 1'b0; axi.rresp = 2'b00;
      if (v.kind == 0) begin
        chk({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd1);
        chk({tag, "_if_inst"}, {32'd0, if_inst}, v.e_out);
        chk({tag, "_if_pc"}, if_pc, v.addr);
        chk({tag, "_data_valid_quiet"}, {63'd0, data_valid}, 64'd0);
      end else begin
        chk({tag, "_data_valid"}, {63'd0, data_valid}, 64'd1);
        chk({tag, "_data_temp"}, data_temp, v.e_out);
        chk({tag, "_inst_valid_quiet"}, {63'd0, inst_valid}, 64'd0);
      end
    end else begin
      chk({tag, "_awvalid"}, {63'd0, axi.awvalid}, 64'd1);
      chk({tag, "_wvalid"}, {63'd0, axi.wvalid}, 64'd1);
      chk({tag, "_awaddr"}, {32'd0, axi.awaddr}, {32'd0, v.addr[31:0]});
      chk({tag, "_awsize"}, {61'd0, axi.awsize}, {61'd0, v.e_size});
      chk({tag, "_wstrb"}, {56'd0, axi.wstrb}, {56'd0, v.e_strb});
      chk({tag, "_wdata"}, axi.wdata, v.e_wdata);
      axi.awready = 1'b1; axi.wready = 1'b1;
      tick();
      axi.awready = 1'b0; axi.wready = 1'b0;
      chk({tag, "_bready"}, {63'd0, axi.bready}, 64'd1);
      chk({tag, "_aw_w_drop"}, {62'd0, axi.awvalid, axi.wvalid}, 64'd0);
      axi.bvalid = 1'b1; axi.bresp = v.resp;
      tick();
      axi.bvalid = 1'b0; axi.bresp = 2'b00;
      chk({tag, "_data_valid"}, {63'd0, data_valid}, 64'd1);
    end
    chk({tag, "_bus_err"}, {63'd0, bus_err}, {63'd0, v.e_err});
    chk({tag, "_idle"}, {61'd0, axi.arvalid, axi.awvalid, axi.bready}, 64'd0);
    tick();
    chk({tag, "_pulse_end"}, {61'd0, inst_valid, data_valid, bus_err}, 64'd0);
  endtask

  initial begin
    //        kind addr                   sz  sdata                  rdata                  rsp wait esz strb   wdata                  out                    err
    vecs[0] = '{0, 64'h0000_0000_8000_0004, 3'd0, 64'h0,                64'h0050_0093_0000_0013, 2'd0, 0, 3'd2, 8'h00, 64'h0,                64'h0000_0000_0050_0093, 1'b0};
    vecs[1] = '{0, 64'h0000_0000_8000_0008, 3'd0, 64'h0,                64'h0050_0093_0000_0013, 2'd0, 0, 3'd2, 8'h00, 64'h0,                64'h0000_0000_0000_0013, 1'b0};
    vecs[2] = '{1, 64'h0000_0000_8000_1000, 3'd3, 64'h0,                64'h0123_4567_89AB_CDEF, 2'd0, 0, 3'd3, 8'h00, 64'h0,                64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[3] = '{1, 64'h0000_0000_8000_1006, 3'd1, 64'h0,                64'h0123_4567_89AB_CDEF, 2'd0, 0, 3'd1, 8'h00, 64'h0,                64'h0000_0000_0000_0123, 1'b0};
    vecs[4] = '{1, 64'h0000_0000_8000_1004, 3'd2, 64'h0,                64'h0123_4567_89AB_CDEF, 2'd2, 0, 3'd2, 8'h00, 64'h0,                64'h0000_0000_0123_4567, 1'b1};
    vecs[5] = '{0, 64'h0000_0000_8000_000C, 3'd0, 64'h0,                64'hDEAD_BEEF_0BAD_F00D, 2'd0, 4, 3'd2, 8'h00, 64'h0,                64'h0000_0000_DEAD_BEEF, 1'b0};
    vecs[6] = '{2, 64'h0000_0000_8000_2000, 3'd3, 64'h1122_3344_5566_7788, 64'h0, 2'd0, 0, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0};
    vecs[7] = '{2, 64'h0000_0000_8000_2004, 3'd2, 64'h0000_0000_DEAD_BEEF, 64'h0, 2'd0, 0, 3'd2, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 1'b0};
    vecs[8] = '{2, 64'h0000_0000_8000_2001, 3'd0, 64'h0000_0000_0000_005A, 64'h0, 2'd0, 0, 3'd0, 8'h02, 64'h0000_0000_0000_5A00, 64'h0, 1'b0};
    vecs[9] = '{2, 64'h0000_0000_8000_2002, 3'd1, 64'h0000_0000_0000_1234, 64'h0, 2'd2, 0, 3'd1, 8'h0C, 64'h0000_0000_1234_0000, 64'h0, 1'b1};

    clear_core();
    clear_slave();
    rst = 1'b1;
    tick(); tick();
    chk("rst_bus_valids", {59'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 64'd0);
    chk("rst_pulses", {61'd0, inst_valid, data_valid, bus_err}, 64'd0);
    chk("rst_regs", {32'd0, if_inst} | if_pc | data_temp, 64'd0);
    chk("rst_addr_data", {32'd0, axi.araddr} | {32'd0, axi.awaddr} | axi.wdata | {56'd0, axi.wstrb}, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Load and fetch requested together: load goes first, fetch follows.
    if_core_ready = 1'b1; if_pc_next = 64'h8000_0010;
    re = 1'b1; data_pc = 64'h8000_1003; data_size = 3'd0;
    tick();
    re = 1'b0; data_pc = 64'h0;
    chk("prio_load_addr", {32'd0, axi.araddr}, 64'h8000_1003);
    chk("prio_load_size", {61'd0, axi.arsize}, 64'd0);
    axi.arready = 1'b1; tick(); axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 64'h1122_3344_AABB_CCDD; tick(); axi.rvalid = 1'b0;
    chk("prio_load_valid", {62'd0, data_valid, inst_valid}, 64'd2);
    chk("prio_load_data", data_temp, 64'h0000_0011_2233_44AA);
    tick();
    if_core_ready = 1'b0;
    chk("prio_fetch_arvalid", {63'd0, axi.arvalid}, 64'd1);
    chk("prio_fetch_addr", {32'd0, axi.araddr}, 64'h8000_0010);
    chk("prio_fetch_size", {61'd0, axi.arsize}, 64'd2);
    axi.arready = 1'b1; tick(); axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 64'hCAFE_F00D_1234_5678; tick(); axi.rvalid = 1'b0;
    chk("prio_fetch_inst", {31'd0, inst_valid, if_inst}, {31'd0, 1'b1, 32'h1234_5678});
    tick();

    // Store with W accepted before AW, and a late B.
    we = 1'b1; data_pc = 64'h8000_2006; data_size = 3'd1; ls_data_o = 64'hBEEF;
    tick();
    clear_core();
    chk("st_wstrb", {56'd0, axi.wstrb}, 64'hC0);
    chk("st_wdata", axi.wdata, 64'hBEEF_0000_0000_0000);
    axi.wready = 1'b1; tick(); axi.wready = 1'b0;
    chk("st_w_only", {61'd0, axi.awvalid, axi.wvalid, axi.bready}, 64'b100);
    axi.awready = 1'b1; tick(); axi.awready = 1'b0;
    chk("st_resp_phase", {61'd0, axi.awvalid, axi.wvalid, axi.bready}, 64'b001);
    tick();
    chk("st_no_early_valid", {63'd0, data_valid}, 64'd0);
    axi.bvalid = 1'b1; tick(); axi.bvalid = 1'b0;
    chk("st_data_valid", {62'd0, data_valid, bus_err}, 64'b10);
    tick();

    // Asynchronous reset while waiting in RD_DATA, then a fresh fetch.
    if_core_ready = 1'b1; if_pc_next = 64'h8000_0020;
    tick();
    clear_core();
    axi.arready = 1'b1; tick(); axi.arready = 1'b0;
    chk("ar_rd_data", {63'd0, axi.rready}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_bus_off", {59'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 64'd0);
    chk("ar_resp_off", {61'd0, inst_valid, data_valid, bus_err}, 64'd0);
    chk("ar_regs_off", {32'd0, if_inst} | data_temp, 64'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    run_vec(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axi_mem_bridge
`default_nettype wire
